// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller, LSB first, one full adder
// and one carry flop. The result is ready WIDTH+1 cycles after start is
// accepted, regardless of the operand values.
// Optional feature: define SERIAL_ADD_SUB_EN to add the `sub` port, which
// turns the operation into a - b (mod 2^WIDTH) with cout = no-borrow.
//
// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// SHIFT | one operand bit per cycle through the full adder
// DONE  | one-cycle done pulse, then back to IDLE

module serial_add_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             fa_b, fa_sum, fa_cout;
  logic             carry_in;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_q, sub_d;

  // subtraction: a + ~b + 1, so B is inverted at the adder and carry-in is 1
  assign fa_b     = b_sh_q[0] ^ sub_q;
  assign carry_in = sub;
`else
  assign fa_b     = b_sh_q[0];
  assign carry_in = 1'b0;
`endif

  serial_add_fa fa (
    .a_i (a_sh_q[0]),
    .b_i (fa_b),
    .c_i (carry_q),
    .s_o (fa_sum),
    .c_o (fa_cout)
  );

  // next-state and datapath updates; every register holds by default
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          sum_d   = '0;
          cout_d  = 1'b0;
          cnt_d   = '0;
          carry_d = carry_in;
`ifdef SERIAL_ADD_SUB_EN
          sub_d   = sub;
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        carry_d = fa_cout;
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          cout_d  = fa_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl (WIDTH=8). Expected {cout,sum} values are
// queued when an operation is started and checked when done pulses.
// Timing, hold, restart-immunity and reset behaviour are checked in the
// individual test tasks.

module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif
  logic [W-1:0] sum;
  logic         cout, busy, done;

  int n_vec = 0;
  int n_err = 0;
  logic [W:0] sb[$];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .sum   (sum),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // scoreboard: every done pulse must match the oldest queued result
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: done seen with nothing queued, sum=%h cout=%b", sum, cout);
      end else begin
        logic [W:0] e;
        e = sb.pop_front();
        if ({cout, sum} !== e) begin
          n_err++;
          $display("FAIL result: got cout=%b sum=%h, want cout=%b sum=%h", cout, sum, e[W], e[W-1:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drive start for one edge and queue the expected result; returns in cycle 1
  task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub);
    logic [W:0] e;
    if (isub) e = {(ia >= ib), W'(ia - ib)};
    else      e = {1'b0, ia} + {1'b0, ib};
    a = ia;
    b = ib;
`ifdef SERIAL_ADD_SUB_EN
    sub = isub;
`endif
    start = 1'b1;
    sb.push_back(e);
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) step();
    n_vec++;
    if ({sum, cout, busy, done} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got sum=%h cout=%b busy=%b done=%b, want all 0", sum, cout, busy, done);
    end
  endtask

  // start on the first edge after reset release, check busy/done timing
  task automatic test_basic();
    rst = 1'b0;
    start_op(8'h3C, 8'h25, 1'b0);
    for (int c = 1; c <= 11; c++) begin
      n_vec++;
      if (busy !== (c <= W) || done !== (c == W + 1)) begin
        n_err++;
        $display("FAIL basic_timing: cycle %0d got busy=%b done=%b, want busy=%b done=%b",
                 c, busy, done, (c <= W), (c == W + 1));
      end
      step();
    end
  endtask

  task automatic test_overflow_hold();
    int n;
    start_op(8'hFF, 8'h01, 1'b0);
    n = 1;
    while (done !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    n_vec++;
    if (n >= 30) begin
      n_err++;
      $display("FAIL overflow_timeout: done not seen, got %0d cycles, want 9", n);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++;
      if (sum !== 8'h00 || cout !== 1'b1 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL overflow_hold: idle %0d got sum=%h cout=%b busy=%b, want sum=00 cout=1 busy=0",
                 i, sum, cout, busy);
      end
    end
  endtask

  // start re-asserted mid-operation and through DONE must be ignored
  task automatic test_restart_ignored();
    start_op(8'h0F, 8'h01, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      if (c == 4) begin
        a = 8'h11;
        b = 8'h11;
        start = 1'b1;
      end
      if (c == 10) start = 1'b0;
      n_vec++;
      if (busy !== (c <= W) || done !== (c == W + 1)) begin
        n_err++;
        $display("FAIL restart_timing: cycle %0d got busy=%b done=%b, want busy=%b done=%b",
                 c, busy, done, (c <= W), (c == W + 1));
      end
      step();
    end
    n_vec++;
    if (busy !== 1'b0 || sum !== 8'h10) begin
      n_err++;
      $display("FAIL restart_after: got busy=%b sum=%h, want busy=0 sum=10", busy, sum);
    end
  endtask

  task automatic test_reset_abort();
    int n;
    a = 8'h55;
    b = 8'h66;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++;
    if ({sum, cout, busy, done} !== '0) begin
      n_err++;
      $display("FAIL abort_outputs: got sum=%h cout=%b busy=%b done=%b, want all 0", sum, cout, busy, done);
    end
    repeat (6) step();
    start_op(8'h02, 8'h03, 1'b0);
    n = 1;
    while (done !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    n_vec++;
    if (n != W + 1) begin
      n_err++;
      $display("FAIL abort_restart_latency: got %0d cycles, want %0d", n, W + 1);
    end
    step();
  endtask

  task automatic test_start_with_rst();
    a = 8'hAA;
    b = 8'h55;
    start = 1'b1;
    rst = 1'b1;
    step();
    start = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00) begin
        n_err++;
        $display("FAIL start_rst: cycle %0d got busy=%b done=%b sum=%h, want 0 0 00", i, busy, done, sum);
      end
      step();
    end
  endtask

  // random operands, each started in the IDLE cycle right after done
  task automatic test_back_to_back();
    int n;
    for (int k = 0; k < 6; k++) begin
      start_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'b0);
      n = 1;
      while (done !== 1'b1 && n < 30) begin
        step();
        n++;
      end
      n_vec++;
      if (n != W + 1) begin
        n_err++;
        $display("FAIL b2b_latency: op %0d got %0d cycles, want %0d", k, n, W + 1);
      end
      step();
    end
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    int n;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) start_op(8'h10, 8'h20, 1'b1);
      else        start_op(8'h20, 8'h10, 1'b1);
      n = 1;
      while (done !== 1'b1 && n < 30) begin
        step();
        n++;
      end
      n_vec++;
      if (n != W + 1) begin
        n_err++;
        $display("FAIL sub_latency: op %0d got %0d cycles, want %0d", k, n, W + 1);
      end
      step();
    end
    sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_overflow_hold();
    test_restart_ignored();
    test_reset_abort();
    test_start_with_rst();
    test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    repeat (2) step();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL missing_done: got %0d results outstanding, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, meaning the operand width in bits (legal range 2..32).
REQ-002 The ports SHALL be, clock and reset first:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an addition.
- a  input  WIDTH  operand A, sampled only when start is accepted.
- b  input  WIDTH  operand B, sampled only when start is accepted.
- sum  output  WIDTH  result register.
- cout  output  1  final carry-out.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle completion pulse.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.

Function
REQ-004 The block SHALL compute a+b bit-serially, LSB first, using exactly one full-adder instance (fa) and one carry flip-flop.
REQ-005 The FSM SHALL have three states:
- IDLE: waits for start.
- SHIFT: processes one bit per cycle.
- DONE: pulses done for one cycle.
REQ-006 In IDLE, when start=1 at a rising edge, the block SHALL:
- load a and b into internal shift registers;
- clear the bit counter;
- load the carry flip-flop with the carry-in (0 for add);
- enter SHIFT.
REQ-007 In each SHIFT cycle, the block SHALL:
- feed the fa with shift-register bit 0 of A, bit 0 of B and the carry flip-flop;
- shift the fa sum bit into the MSB of sum (sum shifts right by one);
- register the fa carry into the carry flip-flop;
- shift the A and B registers right by one;
- increment the bit counter.
REQ-008 After the WIDTH-th SHIFT cycle, the block SHALL enter DONE, leaving sum holding the full result and cout equal to the final carry.
REQ-009 Timing relative to start accepted at edge 0:
- busy SHALL be high in cycles 1..WIDTH;
- done SHALL be high in cycle WIDTH+1 only;
- the FSM SHALL return to IDLE at edge WIDTH+1.
REQ-010 Latency from start acceptance to done SHALL be exactly WIDTH+1 cycles, independent of the operand values.
REQ-011 The block SHALL ignore start while in SHIFT or DONE; no reload, no restart, and no effect on the result in progress.
REQ-012 sum and cout SHALL hold their final values from DONE until the next accepted start.
REQ-013 When start is accepted, sum and cout SHALL be cleared to 0 at that same edge.
REQ-014 Overflow SHALL be reported only through cout; sum wraps modulo 2^WIDTH.
REQ-015 The bit counter SHALL be clog2(WIDTH)+1 bits wide and SHALL NOT wrap during a valid operation.

Reset
REQ-016 While rst=1 at a rising edge, the block SHALL force:
- state to IDLE;
- sum=0, cout=0, busy=0, done=0;
- carry flip-flop, shift registers and bit counter to 0.
REQ-017 rst SHALL take priority over start.
REQ-018 A reset during SHIFT or DONE SHALL abort the operation with no done pulse.
REQ-019 The block SHALL accept start on the first edge after rst deasserts.

Configuration
REQ-020 When SERIAL_ADD_SUB_EN is defined, the block SHALL:
- add input port sub (1 bit), sampled when start is accepted;
- when sub=1, feed inverted B bits to the fa and load the carry flip-flop with 1, computing a-b modulo 2^WIDTH;
- set cout=1 when a>=b (unsigned, no borrow).
REQ-021 When SERIAL_ADD_SUB_EN is not defined, the sub port and the inversion logic SHALL NOT exist, and the carry-in SHALL always be 0.

Verification (WIDTH=8)
REQ-022 The bench SHALL cover:
- a=0x3C, b=0x25, start at edge 0 -> busy cycles 1..8, done in cycle 9 only, sum=0x61, cout=0.
- a=0xFF, b=0x01 -> sum=0x00, cout=1; sum and cout held unchanged for 5 idle cycles after done.
- start re-pulsed with a=0x11, b=0x11 during cycle 4 of an operation with a=0x0F, b=0x01 -> result sum=0x10, cout=0, done still in cycle 9.
- rst asserted in cycle 5 of an operation -> all outputs 0 next cycle, no done pulse; a new start with a=0x02, b=0x03 -> sum=0x05.
- start and rst both high at the same edge -> block stays in IDLE, busy=0.
- (SERIAL_ADD_SUB_EN) sub=1, a=0x10, b=0x20 -> sum=0xF0, cout=0; sub=1, a=0x20, b=0x10 -> sum=0x10, cout=1.
